mul_issuer: RTL
===============

# mul_issuer

Initiator-side controller for the 4-bit sequential multiplier. Accepts operand pairs from an upstream valid/ready stream and drives `a`, `b` and a one-cycle `load` pulse to the multiplier. It then waits for `op_ready`, captures `product`, and presents it on a downstream valid/ready result stream. A watchdog flags operations that never complete. The block sits between the test/host logic and the multiplier's `multiplier` modport.

## Interface
- `OP_W`, default 4: operand width.
- `PROD_W`, default 8: product width; must equal 2*`OP_W`.
- `TIMEOUT`, default 15: maximum WAIT cycles before the operation is abandoned; range 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  issuer can accept an operand pair.
- `in_a`, `in_b`  in  OP_W  operands.
- `a`, `b`  out  OP_W  operands to the multiplier.
- `load`  out  1  start pulse to the multiplier.
- `op_ready`  in  1  multiplier reports that `product` is valid.
- `product`  in  PROD_W  multiplier result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_product`  out  PROD_W  captured product; 0 on timeout.
- `res_timeout`  out  1  result is a timeout marker, not a product.
- `op_count`  out  8  completed non-timeout operations; wraps 255→0.

## Operation
- FSM states: IDLE, LOAD, WAIT, HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, capture `in_a`/`in_b` into `a`/`b` and go to LOAD.
- **LOAD**
  - `load`=1 for exactly one cycle.
  - Clear the watchdog counter.
  - Go to WAIT unconditionally.
- **WAIT**
  - `load`=0; the counter increments every cycle.
  - If `op_ready`=1: capture `product` into `res_product`, set `res_timeout`=0, increment `op_count`, go to HOLD.
  - Else if the counter reaches `TIMEOUT`: set `res_product`=0 and `res_timeout`=1, go to HOLD. `op_count` is not incremented.
  - If `op_ready` and the timeout occur in the same cycle, `op_ready` wins.
- **HOLD**
  - `res_valid`=1; `res_product` and `res_timeout` stay stable.
  - On `res_ready`, go to IDLE.
- `a`/`b` stay stable from the capture edge until the next capture. They are not cleared on return to IDLE.
- `op_ready` is ignored in IDLE, LOAD and HOLD: a spurious or stale high causes no state change.
- `in_ready` is 0 in LOAD, WAIT and HOLD. Upstream holds its data until accepted.
- **Reset mid-operation:** asynchronously returns to IDLE and zeroes all outputs; `in_ready` rises after reset deasserts. Any in-flight multiplier operation is abandoned. A later `op_ready` arriving in IDLE is ignored.

## Timing
- **Reset values:** `in_ready`=0 while `rst` is high and 1 from the first clock after release. `a`=`b`=0, `load`=0, `res_valid`=0, `res_product`=0, `res_timeout`=0, `op_count`=0.
- **Accept → load:** handshake at edge N ⇒ `load`=1 during cycle N..N+1, with `a`/`b` already valid in that cycle.
- **Fastest completion:** `op_ready` sampled high at edge N+2 (first WAIT cycle) ⇒ `res_valid`=1 from N+2.
- **General case:** `op_ready` sampled high at edge M ⇒ `res_valid` and the new `op_count` visible after M.
- **Timeout:** `res_valid` with `res_timeout`=1 appears `TIMEOUT` cycles after entering WAIT.
- **Result handshake:** `res_valid`&`res_ready` at edge K ⇒ `in_ready`=1 after K. Next earliest accept is at K+1.
- **Throughput:** one operation per at least 4 cycles when the result is accepted immediately.

## Structure
- Shared package `mul_pkg`:
  - `OP_W`/`PROD_W` defaults.
  - `mul_iss_state_e` enum {IDLE, LOAD, WAIT, HOLD}.
  - Default `TIMEOUT` constant.
- One sub-module, `mul_watchdog`: cleared by LOAD, enabled in WAIT, outputs `expired` when count == `TIMEOUT`.
- The multiplier-side ports map one-to-one onto the existing multiplier interface signals.

## Test plan
- **Basic operation:** reset, then offer a=3, b=5; model multiplier asserts `op_ready` 4 cycles after `load` with product 15 ⇒ `load` is exactly 1 cycle wide, `res_product`=15, `res_timeout`=0, `op_count`=1.
- **Extremes with backpressure:** a=15, b=15 (product 225), then a=0, b=9 (product 0), with `res_ready` held low 5 cycles ⇒ `res_valid` and data stay stable throughout, `in_ready`=0 until accepted, and results arrive in order.
- **Timeout:** `TIMEOUT`=15, `op_ready` never asserted ⇒ after 15 WAIT cycles `res_valid`=1, `res_timeout`=1, `res_product`=0, `op_count` unchanged.
- **Spurious `op_ready`:** `op_ready` held high while in IDLE and during the LOAD cycle ⇒ no capture before WAIT; the first WAIT cycle captures.
- **Reset mid-WAIT:** assert `rst` mid-WAIT, then release ⇒ all outputs 0 immediately; a late `op_ready` with product 42 produces no `res_valid`.
- **Counter wrap:** 256 back-to-back operations ⇒ `op_count` wraps to 0, and the minimum operation period is 4 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential-multiplier issuer: default widths,
// the default watchdog limit and the issuer state encoding.
package mul_pkg;

  localparam int MUL_OP_W    = 4;
  localparam int MUL_PROD_W  = 8;
  localparam int MUL_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } mul_iss_state_e;

endpackage

// File: rtl/mul_watchdog.sv
// WAIT-phase cycle counter for the multiplier issuer; flags an operation that
// has used up its TIMEOUT budget of WAIT cycles.
module mul_watchdog
  import mul_pkg::*;
#(
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Raised in the WAIT cycle whose closing edge brings the count to TIMEOUT,
  // so the owner can act on that same edge.
  assign expired = (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_issuer.sv
// Initiator-side controller for the 4-bit sequential multiplier: takes operand
// pairs from a valid/ready stream, launches the multiplier and returns results.
module mul_issuer
  import mul_pkg::*;
#(
  parameter int OP_W    = MUL_OP_W,
  parameter int PROD_W  = MUL_PROD_W,
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  output logic              load,
  input  logic              op_ready,
  input  logic [PROD_W-1:0] product,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_product,
  output logic              res_timeout,
  output logic [7:0]        op_count
);

  mul_iss_state_e state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [PROD_W-1:0] res_product_q, res_product_d;
  logic              res_timeout_q, res_timeout_d;
  logic [7:0]        op_count_q, op_count_d;
  logic              live_q, live_d;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_expired;

  // Keeps in_ready low until the first clock edge after reset release.
  assign live_d = 1'b1;

  assign wd_clr = (state_q == LOAD);
  assign wd_en  = (state_q == WAIT);

  mul_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    res_product_d = res_product_q;
    res_timeout_d = res_timeout_q;
    op_count_d    = op_count_q;
    in_ready      = 1'b0;
    load          = 1'b0;
    res_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = live_q;
        if (in_valid && live_q) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving on the expiry cycle still counts as a product.
        if (op_ready) begin
          res_product_d = product;
          res_timeout_d = 1'b0;
          op_count_d    = op_count_q + 8'd1;
          state_d       = HOLD;
        end else if (wd_expired) begin
          res_product_d = '0;
          res_timeout_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      res_product_q <= '0;
      res_timeout_q <= 1'b0;
      op_count_q    <= 8'd0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_product_q <= res_product_d;
      res_timeout_q <= res_timeout_d;
      op_count_q    <= op_count_d;
      live_q        <= live_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign res_product = res_product_q;
  assign res_timeout = res_timeout_q;
  assign op_count    = op_count_q;

endmodule
